// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ALU operations until both operands
// are available (directly or via CDB wakeup), then issues them one at a time
// to a single execute unit through a two-state IDLE/BUSY issue FSM.
module reservation_station #(
   parameter int NUM_ENTRIES = 4,
   parameter int TAG_W       = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   // dispatch from decode
   input  logic                               disp_valid,
   output logic                               disp_ready,
   input  logic [4:0]                         disp_aluop,
   input  logic [63:0]                        disp_vala,
   input  logic [63:0]                        disp_valb,
   input  logic                               disp_vala_rdy,
   input  logic                               disp_valb_rdy,
   input  logic [TAG_W-1:0]                   disp_vala_tag,
   input  logic [TAG_W-1:0]                   disp_valb_tag,
   input  logic [5:0]                         disp_valhw,
   input  logic [TAG_W-1:0]                   disp_dst_tag,
   // common data bus
   input  logic                               cdb_valid,
   input  logic [TAG_W-1:0]                   cdb_tag,
   input  logic [63:0]                        cdb_value,
   // issue to execute unit
   output logic                               alu_start,
   output logic [4:0]                         alu_op,
   output logic [63:0]                        alu_vala,
   output logic [63:0]                        alu_valb,
   output logic [5:0]                         alu_valhw,
   output logic [TAG_W-1:0]                   alu_dst_tag,
   input  logic                               alu_done,
   output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy
);

   localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   typedef struct packed {
      logic             valid;
      logic [4:0]       op;
      logic [5:0]       valhw;
      logic [TAG_W-1:0] dst_tag;
      logic [63:0]      vala;
      logic             a_rdy;
      logic [TAG_W-1:0] a_tag;
      logic [63:0]      valb;
      logic             b_rdy;
      logic [TAG_W-1:0] b_tag;
   } entry_t;

   typedef enum logic {IDLE, BUSY} state_t;

   entry_t                 ent_q [NUM_ENTRIES];
   entry_t                 ent_d [NUM_ENTRIES];
   logic [OCC_W-1:0]       occ_q, occ_d;
   state_t                 state_q;
   logic                   alu_start_q;
   logic [4:0]             alu_op_q;
   logic [63:0]            alu_vala_q, alu_valb_q;
   logic [5:0]             alu_valhw_q;
   logic [TAG_W-1:0]       alu_dst_tag_q;

   logic                   disp_fire;
   logic                   issue;
   logic                   any_ready;
   logic [IDX_W-1:0]       free_idx, rdy_idx;
   entry_t                 new_ent;

   assign disp_ready = (occ_q < OCC_W'(NUM_ENTRIES));
   assign disp_fire  = disp_valid && disp_ready;
   assign issue      = (state_q == IDLE) && any_ready;

   // Pick lowest-index free slot and lowest-index ready entry from registered state
   always_comb begin
      // NOTE: combinational blocks use blocking '=' and give every output a
      // default first, so no path leaves a value unassigned (no latch).
      free_idx  = '0;
      rdy_idx   = '0;
      any_ready = 1'b0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!ent_q[i].valid) free_idx = IDX_W'(i);
         if (ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
            rdy_idx   = IDX_W'(i);
            any_ready = 1'b1;
         end
      end
   end

   // Build the incoming entry, bypassing a same-cycle CDB result into waiting operands
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.op      = disp_aluop;
      new_ent.valhw   = disp_valhw;
      new_ent.dst_tag = disp_dst_tag;
      new_ent.a_tag   = disp_vala_tag;
      new_ent.b_tag   = disp_valb_tag;
      new_ent.vala    = disp_vala;
      new_ent.a_rdy   = disp_vala_rdy;
      new_ent.valb    = disp_valb;
      new_ent.b_rdy   = disp_valb_rdy;
      if (!disp_vala_rdy && cdb_valid && (disp_vala_tag == cdb_tag)) begin
         new_ent.vala  = cdb_value;
         new_ent.a_rdy = 1'b1;
      end
      if (!disp_valb_rdy && cdb_valid && (disp_valb_tag == cdb_tag)) begin
         new_ent.valb  = cdb_value;
         new_ent.b_rdy = 1'b1;
      end
   end

   // Next entry state: CDB wakeup, then issue invalidation, then dispatch write
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         ent_d[i] = ent_q[i];
         if (cdb_valid && ent_q[i].valid) begin
            if (!ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
               ent_d[i].vala  = cdb_value;
               ent_d[i].a_rdy = 1'b1;
            end
            if (!ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_tag)) begin
               ent_d[i].valb  = cdb_value;
               ent_d[i].b_rdy = 1'b1;
            end
         end
         if (issue && (rdy_idx == IDX_W'(i))) ent_d[i].valid = 1'b0;
         if (disp_fire && (free_idx == IDX_W'(i))) ent_d[i] = new_ent;
      end
      occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue);
   end

   // Entry storage and occupancy counter
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: only control bits (valid/rdy) are reset; operand payloads are
         // never read while invalid, so they are left unreset.
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_q[i].valid <= 1'b0;
            ent_q[i].a_rdy <= 1'b0;
            ent_q[i].b_rdy <= 1'b0;
         end
         occ_q <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
         occ_q <= occ_d;
      end
   end

   // Issue FSM with registered execute-unit outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         alu_start_q   <= 1'b0;
         alu_op_q      <= '0;
         alu_vala_q    <= '0;
         alu_valb_q    <= '0;
         alu_valhw_q   <= '0;
         alu_dst_tag_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (any_ready) begin
                  alu_start_q   <= 1'b1;
                  alu_op_q      <= ent_q[rdy_idx].op;
                  alu_vala_q    <= ent_q[rdy_idx].vala;
                  alu_valb_q    <= ent_q[rdy_idx].valb;
                  alu_valhw_q   <= ent_q[rdy_idx].valhw;
                  alu_dst_tag_q <= ent_q[rdy_idx].dst_tag;
                  state_q       <= BUSY;
               end else begin
                  alu_start_q   <= 1'b0;
               end
            end
            BUSY: begin
               alu_start_q <= 1'b0;
               if (alu_done) state_q <= IDLE;
            end
            default: begin
               alu_start_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign alu_start   = alu_start_q;
   assign alu_op      = alu_op_q;
   assign alu_vala    = alu_vala_q;
   assign alu_valb    = alu_valb_q;
   assign alu_valhw   = alu_valhw_q;
   assign alu_dst_tag = alu_dst_tag_q;
   assign occupancy   = occ_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed table-driven bench for reservation_station. Each row gives the
// inputs driven during one cycle and the outputs expected in that same cycle.
module tb_reservation_station;

   localparam int N     = 4;
   localparam int TW    = 4;
   localparam int OCC_W = $clog2(N + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            disp_valid, disp_ready;
   logic [4:0]      disp_aluop;
   logic [63:0]     disp_vala, disp_valb;
   logic            disp_vala_rdy, disp_valb_rdy;
   logic [TW-1:0]   disp_vala_tag, disp_valb_tag;
   logic [5:0]      disp_valhw;
   logic [TW-1:0]   disp_dst_tag;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [63:0]     cdb_value;
   logic            alu_start;
   logic [4:0]      alu_op;
   logic [63:0]     alu_vala, alu_valb;
   logic [5:0]      alu_valhw;
   logic [TW-1:0]   alu_dst_tag;
   logic            alu_done;
   logic [OCC_W-1:0] occupancy;

   reservation_station #(.NUM_ENTRIES(N), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_aluop(disp_aluop),
      .disp_vala(disp_vala), .disp_valb(disp_valb),
      .disp_vala_rdy(disp_vala_rdy), .disp_valb_rdy(disp_valb_rdy),
      .disp_vala_tag(disp_vala_tag), .disp_valb_tag(disp_valb_tag),
      .disp_valhw(disp_valhw), .disp_dst_tag(disp_dst_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .alu_start(alu_start), .alu_op(alu_op), .alu_vala(alu_vala), .alu_valb(alu_valb),
      .alu_valhw(alu_valhw), .alu_dst_tag(alu_dst_tag), .alu_done(alu_done),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, dv;
      logic [4:0]  op;
      logic [63:0] a;  logic ar; logic [TW-1:0] at;
      logic [63:0] b;  logic br; logic [TW-1:0] bt;
      logic [5:0]  hw;
      logic [TW-1:0] dst;
      logic        cv; logic [TW-1:0] ct; logic [63:0] cval;
      logic        done;
      logic        e_start, e_ready;
      logic [OCC_W-1:0] e_occ;
      logic [4:0]  e_op;
      logic [63:0] e_a, e_b;
      logic [5:0]  e_hw;
      logic [TW-1:0] e_dst;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   function automatic vec_t s(logic rst_v, logic dv, logic [4:0] op,
                              logic [63:0] a, logic ar, logic [TW-1:0] at,
                              logic [63:0] b, logic br, logic [TW-1:0] bt,
                              logic [5:0] hw, logic [TW-1:0] dst,
                              logic cv, logic [TW-1:0] ct, logic [63:0] cval,
                              logic done);
      vec_t r;
      r.rst = rst_v; r.dv = dv; r.op = op;
      r.a = a; r.ar = ar; r.at = at; r.b = b; r.br = br; r.bt = bt;
      r.hw = hw; r.dst = dst; r.cv = cv; r.ct = ct; r.cval = cval; r.done = done;
      r.e_start = 0; r.e_ready = 0; r.e_occ = 0; r.e_op = 0;
      r.e_a = 0; r.e_b = 0; r.e_hw = 0; r.e_dst = 0;
      return r;
   endfunction

   function automatic vec_t idle(logic done);
      return s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, done);
   endfunction

   function automatic vec_t e(vec_t r, logic st, logic rdy, int occ, logic [4:0] op,
                              logic [63:0] a, logic [63:0] b, logic [5:0] hw, logic [TW-1:0] dst);
      r.e_start = st; r.e_ready = rdy; r.e_occ = OCC_W'(occ); r.e_op = op;
      r.e_a = a; r.e_b = b; r.e_hw = hw; r.e_dst = dst;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      rst = r.rst; disp_valid = r.dv; disp_aluop = r.op;
      disp_vala = r.a; disp_vala_rdy = r.ar; disp_vala_tag = r.at;
      disp_valb = r.b; disp_valb_rdy = r.br; disp_valb_tag = r.bt;
      disp_valhw = r.hw; disp_dst_tag = r.dst;
      cdb_valid = r.cv; cdb_tag = r.ct; cdb_value = r.cval; alu_done = r.done;
   endtask

   initial begin
      // ---- test 1: both operands ready, issue two cycles after dispatch
      vecs.push_back(e(s(0,1,5'd1, 64'd5,1,0, 64'd7,1,0, 6'd3,4'd3, 0,0,0, 0), 0,1,0, 0,0,0,0,0));
      vecs.push_back(e(idle(0),                                                  0,1,1, 0,0,0,0,0));
      vecs.push_back(e(idle(1),                                                  1,1,0, 1,5,7,3,3));
      vecs.push_back(e(idle(0),                                                  0,1,0, 1,5,7,3,3));
      // ---- test 2: A waits on tag 2; tag 9 broadcast must not wake it
      vecs.push_back(e(s(0,1,5'd2, 64'd0,0,4'd2, 64'h10,1,0, 6'd10,4'd4, 0,0,0, 0), 0,1,0, 1,5,7,3,3));
      vecs.push_back(e(s(0,0,0, 0,0,0, 0,0,0, 0,0, 1,4'd9,64'h99, 0),               0,1,1, 1,5,7,3,3));
      vecs.push_back(e(idle(0),                                                     0,1,1, 1,5,7,3,3));
      vecs.push_back(e(s(0,0,0, 0,0,0, 0,0,0, 0,0, 1,4'd2,64'hAB, 0),               0,1,1, 1,5,7,3,3));
      vecs.push_back(e(idle(0),                                                     0,1,1, 1,5,7,3,3));
      vecs.push_back(e(idle(1),                                                     1,1,0, 2,64'hAB,64'h10,10,4));
      // ---- test 3: B bypassed from the CDB in the dispatch cycle
      vecs.push_back(e(s(0,1,5'd3, 64'h21,1,0, 64'd0,0,4'd6, 6'd63,4'd5, 1,4'd6,64'h55, 0), 0,1,0, 2,64'hAB,64'h10,10,4));
      vecs.push_back(e(idle(0),                                                     0,1,1, 2,64'hAB,64'h10,10,4));
      vecs.push_back(e(idle(1),                                                     1,1,0, 3,64'h21,64'h55,63,5));
      // ---- test 4: fill the station while the execute unit stays busy
      vecs.push_back(e(s(0,1,5'd4, 64'd1,1,0, 64'd1,1,0, 6'd1,4'd8,  0,0,0, 0), 0,1,0, 3,64'h21,64'h55,63,5));
      vecs.push_back(e(s(0,1,5'd4, 64'd2,1,0, 64'd2,1,0, 6'd2,4'd9,  0,0,0, 0), 0,1,1, 3,64'h21,64'h55,63,5));
      vecs.push_back(e(s(0,1,5'd4, 64'd3,1,0, 64'd3,1,0, 6'd3,4'd10, 0,0,0, 0), 1,1,1, 4,1,1,1,8));
      vecs.push_back(e(s(0,1,5'd4, 64'd4,1,0, 64'd4,1,0, 6'd4,4'd11, 0,0,0, 0), 0,1,2, 4,1,1,1,8));
      vecs.push_back(e(s(0,1,5'd4, 64'd5,1,0, 64'd5,1,0, 6'd5,4'd12, 0,0,0, 0), 0,1,3, 4,1,1,1,8));
      vecs.push_back(e(s(0,1,5'd4, 64'd6,1,0, 64'd6,1,0, 6'd6,4'd13, 0,0,0, 0), 0,0,4, 4,1,1,1,8));
      vecs.push_back(e(idle(1),                                                  0,0,4, 4,1,1,1,8));
      vecs.push_back(e(idle(0),                                                  0,0,4, 4,1,1,1,8));
      // entry 0 was refilled by the third dispatch, so it issues next
      vecs.push_back(e(idle(0),                                                  1,1,3, 4,3,3,3,10));
      // ---- test 5: reset while busy with three entries; inputs during reset ignored
      vecs.push_back(e(s(1,1,5'd7, 64'd7,1,0, 64'd7,1,0, 6'd7,4'd14, 1,4'd0,64'h1, 0), 0,1,3, 4,3,3,3,10));
      vecs.push_back(e(idle(1),                                                  0,1,0, 0,0,0,0,0));
      vecs.push_back(e(s(0,1,5'd5, 64'h77,1,0, 64'h88,1,0, 6'h2A,4'd7, 0,0,0, 0), 0,1,0, 0,0,0,0,0));
      vecs.push_back(e(idle(0),                                                  0,1,1, 0,0,0,0,0));
      vecs.push_back(e(idle(0),                                                  1,1,0, 5,64'h77,64'h88,6'h2A,7));

      // initial reset
      drive(idle(0));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k]);
         check($sformatf("row%0d alu_start", k),   64'(alu_start),   64'(vecs[k].e_start));
         check($sformatf("row%0d disp_ready", k),  64'(disp_ready),  64'(vecs[k].e_ready));
         check($sformatf("row%0d occupancy", k),   64'(occupancy),   64'(vecs[k].e_occ));
         check($sformatf("row%0d alu_op", k),      64'(alu_op),      64'(vecs[k].e_op));
         check($sformatf("row%0d alu_vala", k),    alu_vala,         vecs[k].e_a);
         check($sformatf("row%0d alu_valb", k),    alu_valb,         vecs[k].e_b);
         check($sformatf("row%0d alu_valhw", k),   64'(alu_valhw),   64'(vecs[k].e_hw));
         check($sformatf("row%0d alu_dst_tag", k), 64'(alu_dst_tag), 64'(vecs[k].e_dst));
         @(posedge clk);
         #1;
      end

      // alu_start must be a single-cycle pulse after the last issue
      drive(idle(0));
      check("final alu_start low", 64'(alu_start), 64'd0);
      check("final occupancy", 64'(occupancy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
